// File: rtl/rdc_pkg.sv
// Mode encodings for the source-select / field-reduce stage.
// The control unit imports the same constants.
package rdc_pkg;

  typedef enum logic [1:0] {
    RDC_PASS = 2'b00,
    RDC_ZRED = 2'b01,
    RDC_SRED = 2'b10,
    RDC_HOLD = 2'b11
  } rdc_mode_e;

endpackage : rdc_pkg

// File: rtl/field_reduce.sv
// Combinational field reduction: pass through, or keep the low RW bits
// with zero or sign extension back to WIDTH.
module field_reduce
  import rdc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic [WIDTH-1:0] v,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] r
);

  // NOTE: combinational blocks assign a default first so that no path
  // leaves r unassigned; a missing default would infer a latch.
  always_comb begin
    r = '0;
    case (mode)
      RDC_PASS: r = v;
      RDC_ZRED: r = {{(WIDTH-RW){1'b0}}, v[RW-1:0]};
      RDC_SRED: r = {{(WIDTH-RW){v[RW-1]}}, v[RW-1:0]};
      default:  r = '0;
    endcase
  end

endmodule : field_reduce

// File: rtl/rdc_src_sel_reg.sv
// Registered NSRC:1 source select followed by field reduction, with a
// valid flag and a sticky illegal-select error for the control unit.
module rdc_src_sel_reg
  import rdc_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NSRC   = 2,
  parameter  int RW     = 5,
  localparam int SELW   = $clog2(NSRC),
  localparam int SELW_P = (SELW < 1) ? 1 : SELW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_i,
  input  logic [SELW_P-1:0]     sel_i,
  input  logic [1:0]            mode_i,
  input  logic                  load_i,
  input  logic                  clr_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  output logic                  err_o
);

  // One extra bit so NSRC itself is representable when it is a power of 2.
  localparam logic [SELW_P:0] NSRC_W = (SELW_P+1)'(NSRC);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] red_val;
  logic             sel_legal;

  logic [WIDTH-1:0] data_d,  data_q;
  logic             valid_d, valid_q;
  logic             err_d,   err_q;

  // An out-of-range index matches no slice and leaves sel_val at zero.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == SELW_P'(k)) sel_val = src_i[k*WIDTH +: WIDTH];
    end
  end

  assign sel_legal = ({1'b0, sel_i} < NSRC_W);

  field_reduce #(
    .WIDTH (WIDTH),
    .RW    (RW)
  ) u_field_reduce (
    .v    (sel_val),
    .mode (mode_i),
    .r    (red_val)
  );

  // Priority: clear, then load, then hold. HOLD mode skips the error check.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (clr_i) begin
      data_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (load_i) begin
      case (mode_i)
        RDC_PASS, RDC_ZRED, RDC_SRED: begin
          valid_d = 1'b1;
          if (sel_legal) begin
            data_d = red_val;
          end else begin
            data_d = '0;
            err_d  = 1'b1;
          end
        end
        RDC_HOLD: ;
        default:  data_d = '0;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop samples its _d value from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule : rdc_src_sel_reg

// File: tb/tb_rdc_src_sel_reg.sv
// Directed bench: an NSRC=2 instance for select/reduce/hold/timing and an
// NSRC=3 instance for the illegal-select and sticky-error behaviour.
module tb_rdc_src_sel_reg;
  import rdc_pkg::*;

  logic        clk;
  logic        reset;

  logic [63:0] src2;
  logic        sel2;
  logic [1:0]  mode2;
  logic        load2, clr2;
  logic [31:0] data2;
  logic        valid2, err2;

  logic [95:0] src3;
  logic [1:0]  sel3;
  logic [1:0]  mode3;
  logic        load3, clr3;
  logic [31:0] data3;
  logic        valid3, err3;

  int n_tests = 0;
  int n_fail  = 0;

  rdc_src_sel_reg #(.WIDTH(32), .NSRC(2), .RW(5)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .src_i   (src2),
    .sel_i   (sel2),
    .mode_i  (mode2),
    .load_i  (load2),
    .clr_i   (clr2),
    .data_o  (data2),
    .valid_o (valid2),
    .err_o   (err2)
  );

  rdc_src_sel_reg #(.WIDTH(32), .NSRC(3), .RW(5)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .src_i   (src3),
    .sel_i   (sel3),
    .mode_i  (mode3),
    .load_i  (load3),
    .clr_i   (clr3),
    .data_o  (data3),
    .valid_o (valid3),
    .err_o   (err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    src2 = '0; sel2 = 1'b0; mode2 = RDC_PASS; load2 = 1'b0; clr2 = 1'b0;
    src3 = '0; sel3 = 2'd0; mode3 = RDC_PASS; load3 = 1'b0; clr3 = 1'b0;
    #2;
    n_tests++;
    if ({data2, valid2, err2} !== 34'h0) begin
      $display("FAIL reset_init2: got data=%h valid=%b err=%b, want all 0", data2, valid2, err2);
      n_fail++;
    end
    n_tests++;
    if ({data3, valid3, err3} !== 34'h0) begin
      $display("FAIL reset_init3: got data=%h valid=%b err=%b, want all 0", data3, valid3, err3);
      n_fail++;
    end
    #6 reset = 1'b1;
    src2[31:0] = 32'hDEAD_BEEF; sel2 = 1'b0; mode2 = RDC_PASS; load2 = 1'b1;
    step();
    load2 = 1'b0;
    n_tests++;
    if (data2 !== 32'hDEAD_BEEF || valid2 !== 1'b1) begin
      $display("FAIL reset_preload: got data=%h valid=%b, want deadbeef 1", data2, valid2);
      n_fail++;
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({data2, valid2, err2} !== 34'h0) begin
      $display("FAIL reset_async: got data=%h valid=%b err=%b, want all 0", data2, valid2, err2);
      n_fail++;
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_pass_zred();
    src2 = {32'h0000_07E3, 32'h1234_5678};
    sel2 = 1'b1; mode2 = RDC_ZRED; load2 = 1'b1;
    step();
    n_tests++;
    if (data2 !== 32'h0000_0003 || valid2 !== 1'b1) begin
      $display("FAIL zred_sel1: got data=%h valid=%b, want 00000003 1", data2, valid2);
      n_fail++;
    end
    sel2 = 1'b0; mode2 = RDC_PASS;
    step();
    load2 = 1'b0;
    n_tests++;
    if (data2 !== 32'h1234_5678) begin
      $display("FAIL pass_sel0: got %h want 12345678", data2);
      n_fail++;
    end
  endtask

  task automatic test_sred();
    src2[31:0] = 32'h0000_0013; sel2 = 1'b0; mode2 = RDC_SRED; load2 = 1'b1;
    step();
    n_tests++;
    if (data2 !== 32'hFFFF_FFF3) begin
      $display("FAIL sred_neg: got %h want fffffff3", data2);
      n_fail++;
    end
    src2[31:0] = 32'h0000_000F;
    step();
    load2 = 1'b0;
    n_tests++;
    if (data2 !== 32'h0000_000F) begin
      $display("FAIL sred_pos: got %h want 0000000f", data2);
      n_fail++;
    end
  endtask

  task automatic test_hold();
    // data2 holds 0x0000000F from the previous load
    for (int i = 0; i < 10; i++) begin
      src2  = {$urandom, $urandom};
      sel2  = 1'($urandom);
      mode2 = 2'($urandom);
      load2 = 1'b0;
      step();
      n_tests++;
      if (data2 !== 32'h0000_000F || valid2 !== 1'b1) begin
        $display("FAIL hold_idle[%0d]: got data=%h valid=%b, want 0000000f 1", i, data2, valid2);
        n_fail++;
      end
    end
    src2 = {32'h5555_5555, 32'hAAAA_AAAA}; sel2 = 1'b1; mode2 = RDC_HOLD; load2 = 1'b1;
    step();
    load2 = 1'b0;
    n_tests++;
    if (data2 !== 32'h0000_000F || valid2 !== 1'b1) begin
      $display("FAIL hold_mode: got data=%h valid=%b, want 0000000f 1", data2, valid2);
      n_fail++;
    end
  endtask

  task automatic test_illegal_sel();
    src3 = {32'hCCCC_0017, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    sel3 = 2'd3; mode3 = RDC_PASS; load3 = 1'b1;
    step();
    n_tests++;
    if (data3 !== 32'h0 || err3 !== 1'b1 || valid3 !== 1'b1) begin
      $display("FAIL illegal_load: got data=%h valid=%b err=%b, want 0 1 1", data3, valid3, err3);
      n_fail++;
    end
    sel3 = 2'd2; mode3 = RDC_PASS;
    step();
    n_tests++;
    if (data3 !== 32'hCCCC_0017 || err3 !== 1'b1) begin
      $display("FAIL legal_after_err: got data=%h err=%b, want cccc0017 1", data3, err3);
      n_fail++;
    end
    sel3 = 2'd2; mode3 = RDC_SRED;
    step();
    load3 = 1'b0;
    n_tests++;
    if (data3 !== 32'hFFFF_FFF7 || err3 !== 1'b1) begin
      $display("FAIL sred_sel2: got data=%h err=%b, want fffffff7 1", data3, err3);
      n_fail++;
    end
    clr3 = 1'b1;
    step();
    clr3 = 1'b0;
    n_tests++;
    if ({data3, valid3, err3} !== 34'h0) begin
      $display("FAIL clr_all: got data=%h valid=%b err=%b, want all 0", data3, valid3, err3);
      n_fail++;
    end
    sel3 = 2'd3; mode3 = RDC_HOLD; load3 = 1'b1;
    step();
    load3 = 1'b0;
    n_tests++;
    if ({data3, valid3, err3} !== 34'h0) begin
      $display("FAIL hold_no_errchk: got data=%h valid=%b err=%b, want all 0", data3, valid3, err3);
      n_fail++;
    end
  endtask

  task automatic test_clr_load();
    src2 = {32'h0000_0001, 32'h7777_7777}; sel2 = 1'b0; mode2 = RDC_PASS; load2 = 1'b1;
    step();
    clr2 = 1'b1;
    step();
    clr2 = 1'b0; load2 = 1'b0;
    n_tests++;
    if (data2 !== 32'h0 || valid2 !== 1'b0 || err2 !== 1'b0) begin
      $display("FAIL clr_beats_load: got data=%h valid=%b err=%b, want all 0", data2, valid2, err2);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic        sel_t [5];
    logic [1:0]  mode_t[5];
    logic [31:0] exp_t [5];
    sel_t[0] = 1'b0; mode_t[0] = RDC_PASS; exp_t[0] = 32'hAAAA_5555;
    sel_t[1] = 1'b1; mode_t[1] = RDC_ZRED; exp_t[1] = 32'h0000_0010;
    sel_t[2] = 1'b1; mode_t[2] = RDC_SRED; exp_t[2] = 32'hFFFF_FFF0;
    sel_t[3] = 1'b0; mode_t[3] = RDC_SRED; exp_t[3] = 32'hFFFF_FFF5;
    sel_t[4] = 1'b0; mode_t[4] = RDC_ZRED; exp_t[4] = 32'h0000_0015;
    src2 = {32'h0F0F_F0F0, 32'hAAAA_5555};
    sel2 = sel_t[0]; mode2 = mode_t[0]; load2 = 1'b1;
    #2;
    n_tests++;
    if (data2 !== 32'h0 || valid2 !== 1'b0) begin
      $display("FAIL b2b_no_comb_path: got data=%h valid=%b, want 0 0", data2, valid2);
      n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      sel2 = sel_t[i]; mode2 = mode_t[i]; load2 = 1'b1;
      step();
      n_tests++;
      if (data2 !== exp_t[i] || valid2 !== 1'b1) begin
        $display("FAIL b2b[%0d]: got data=%h valid=%b, want %h 1", i, data2, valid2, exp_t[i]);
        n_fail++;
      end
    end
    load2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_zred();
    test_sred();
    test_hold();
    test_illegal_sel();
    test_clr_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rdc_src_sel_reg
